// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trigger/capture block.
// Optional auto-trigger is enabled in the top by defining SCOPE_AUTO_TRIG_EN.
package scope_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic SLOPE_RISING  = 1'b0;
  localparam logic SLOPE_FALLING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_READY,
    ST_READOUT
  } scope_state_e;

endpackage

// File: rtl/scope_trig_capture_if.sv
// Sample-input, control, readout and status bundle for scope_trig_capture.
// master = stimulus/consumer side, slave = the capture block.
interface scope_trig_capture_if
  import scope_pkg::*;
#(
  parameter int AW = 8
);

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                arm;
  logic [SAMPLE_W-1:0] trig_level;
  logic                trig_slope;
  logic [AW-1:0]       pre_count;
  logic                rd_req;
  logic [SAMPLE_W-1:0] rd_data;
  logic                rd_valid;
  logic                rd_last;
  logic                busy;
  logic                triggered;
  logic                done;

  modport master (
    output sample_in, sample_valid, arm, trig_level, trig_slope, pre_count, rd_req,
    input  rd_data, rd_valid, rd_last, busy, triggered, done
  );

  modport slave (
    input  sample_in, sample_valid, arm, trig_level, trig_slope, pre_count, rd_req,
    output rd_data, rd_valid, rd_last, busy, triggered, done
  );

endinterface

// File: rtl/scope_capture_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port (1-cycle latency).
module scope_capture_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the read register is cleared; the array itself keeps its contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_trig_capture.sv
// Level/slope triggered capture of a pre/post-trigger window into a circular RAM, read out oldest-first.
// Define SCOPE_AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT valid samples in WAIT_TRIG.
module scope_trig_capture
  import scope_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
`ifdef SCOPE_AUTO_TRIG_EN
  , parameter int AUTO_TIMEOUT = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  scope_trig_capture_if.slave  bus
);

  scope_state_e        state_q, state_d;
  logic [SAMPLE_W-1:0] level_q;
  logic [SAMPLE_W-1:0] prev_q;
  logic                slope_q;
  logic                prev_valid_q;
  logic [AW-1:0]       pre_q;
  logic [AW-1:0]       pre_cnt_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       trig_ptr_q;
  logic [AW-1:0]       post_rem_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         rd_cnt_q;
  logic                rd_valid_q;
  logic                rd_last_q;
  logic                busy_q;
  logic                triggered_q;
  logic                done_q;

  logic                capturing;
  logic                wr_en;
  logic                rise_hit;
  logic                fall_hit;
  logic                edge_hit;
  logic                auto_hit;
  logic                trig_hit;
  logic                rd_issue;

  assign capturing = (state_q == ST_PREFILL) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);

  // A POST cycle with nothing left to collect must not overwrite the oldest pre-trigger sample.
  assign wr_en = capturing && bus.sample_valid &&
                 !((state_q == ST_POST) && (post_rem_q == '0));

  assign rise_hit = (prev_q < level_q) && (bus.sample_in >= level_q);
  assign fall_hit = (prev_q > level_q) && (bus.sample_in <= level_q);
  assign edge_hit = prev_valid_q &&
                    (((slope_q == SLOPE_RISING)  && rise_hit) ||
                     ((slope_q == SLOPE_FALLING) && fall_hit));

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] auto_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          auto_cnt_q <= '0;
    else if ((state_q == ST_IDLE) && bus.arm)            auto_cnt_q <= '0;
    else if ((state_q == ST_WAIT_TRIG) && bus.sample_valid) auto_cnt_q <= auto_cnt_q + TW'(1);
  end

  assign auto_hit = (auto_cnt_q == TW'(AUTO_TIMEOUT - 1));
`else
  assign auto_hit = 1'b0;
`endif

  assign trig_hit = (state_q == ST_WAIT_TRIG) && bus.sample_valid && (edge_hit || auto_hit);
  assign rd_issue = (state_q == ST_READOUT) && bus.rd_req && !rd_cnt_q[AW];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.arm) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (pre_q == '0)
          state_d = ST_WAIT_TRIG;
        else if (bus.sample_valid && (pre_cnt_q == pre_q - AW'(1)))
          state_d = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (trig_hit) state_d = ST_POST;
      end
      ST_POST: begin
        if (post_rem_q == '0)
          state_d = ST_READY;
        else if (bus.sample_valid && (post_rem_q == AW'(1)))
          state_d = ST_READY;
      end
      ST_READY: begin
        if (bus.rd_req) state_d = ST_READOUT;
      end
      ST_READOUT: begin
        if (rd_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are derived from the next state so they change together with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      slope_q      <= SLOPE_RISING;
      pre_q        <= '0;
      pre_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_ptr_q   <= '0;
      post_rem_q   <= '0;
      rd_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_READY) || (state_d == ST_READOUT);

      // An AW-bit pre_count cannot exceed DEPTH-1, so latching it is already the clamp.
      if ((state_q == ST_IDLE) && bus.arm) begin
        level_q      <= bus.trig_level;
        slope_q      <= bus.trig_slope;
        pre_q        <= bus.pre_count;
        pre_cnt_q    <= '0;
        wr_ptr_q     <= '0;
        prev_valid_q <= 1'b0;
      end

      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);

      if (capturing && bus.sample_valid) begin
        prev_q       <= bus.sample_in;
        prev_valid_q <= 1'b1;
      end

      if ((state_q == ST_PREFILL) && bus.sample_valid) pre_cnt_q <= pre_cnt_q + AW'(1);

      if (trig_hit) begin
        trig_ptr_q  <= wr_ptr_q;
        triggered_q <= 1'b1;
        post_rem_q  <= AW'(DEPTH - 1) - pre_q;
      end

      if ((state_q == ST_POST) && bus.sample_valid && (post_rem_q != '0))
        post_rem_q <= post_rem_q - AW'(1);

      if (state_q == ST_POST) begin
        rd_ptr_q <= trig_ptr_q - pre_q;
        rd_cnt_q <= '0;
      end

      if (rd_issue) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_cnt_q <= rd_cnt_q + (AW+1)'(1);
      end

      rd_valid_q <= rd_issue;
      rd_last_q  <= rd_issue && (rd_cnt_q == (AW+1)'(DEPTH - 1));

      if (state_d == ST_IDLE) triggered_q <= 1'b0;
    end
  end

  scope_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (SAMPLE_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.sample_in),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.rd_data)
  );

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.busy      = busy_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;

endmodule
